hwpe_ctrl_nested_counter: RTL

- Nested loop index generator for HWPE controllers. Sits directly downstream of the controller register file / microcode package types.
- Consumes per-loop ranges (the `range` field of `uloop_code_t`) and enable/clear control (`ctrl_uloop_t`).
- Emits one index tuple per valid/ready handshake to the streamer/address-generation stage.
- Flags `done` after the last tuple is accepted.

---
 rtl/hwpe_ctrl_nested_counter.sv | 137 +++++++++++++
 1 files changed

// File: rtl/hwpe_ctrl_nested_counter.sv
// hwpe_ctrl_nested_counter: nested loop index generator with valid/ready output.
// Optional macro HWPE_CTRL_NESTED_COUNTER_PERF_EN enables the accepted-tuple counter.
module hwpe_ctrl_nested_counter #(
    parameter int unsigned NB_LOOPS  = 6,
    parameter int unsigned CNT_WIDTH = 12
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic                                 clear_i,
    input  logic                                 enable_i,
    input  logic                                 start_i,
    input  logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   range_i,
    input  logic                                 ready_i,
    output logic                                 valid_o,
    output logic [NB_LOOPS-1:0][CNT_WIDTH-1:0]   idx_o,
    output logic [$clog2(NB_LOOPS)-1:0]          loop_o,
    output logic                                 done_o,
    output logic                                 busy_o,
    output logic [31:0]                          perf_cnt_o
);

    localparam int unsigned LW = $clog2(NB_LOOPS);
    localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

    typedef enum logic {
        IDLE,
        RUN
    } state_e;

    state_e                             state_q, state_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] rng_q, rng_d;
    logic [NB_LOOPS-1:0][CNT_WIDTH-1:0] idx_q, idx_d;
    logic [LW-1:0]                      loop_q, loop_d;
    logic                               done_q, done_d;

    logic [NB_LOOPS-1:0]                at_max;
    logic [NB_LOOPS:0]                  inner_max;
    logic                               xfer;

    assign busy_o  = (state_q == RUN);
    assign valid_o = busy_o & enable_i;
    assign xfer    = valid_o & ready_i;
    assign idx_o   = idx_q;
    assign loop_o  = loop_q;
    assign done_o  = done_q;

    // Carry chain: level k may step only when all inner levels sit at their last value
    always_comb begin
        at_max       = '0;
        inner_max    = '0;
        inner_max[0] = 1'b1;
        for (int k = 0; k < NB_LOOPS; k++) begin
            at_max[k]      = (idx_q[k] == (rng_q[k] - ONE));
            inner_max[k+1] = inner_max[k] & at_max[k];
        end
    end

    // Next-state, range latch and index advance
    always_comb begin
        state_d = state_q;
        rng_d   = rng_q;
        idx_d   = idx_q;
        loop_d  = loop_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i && enable_i) begin
                    state_d = RUN;
                    for (int k = 0; k < NB_LOOPS; k++) begin
                        rng_d[k] = (range_i[k] == '0) ? ONE : range_i[k];
                    end
                    idx_d  = '0;
                    loop_d = LW'(NB_LOOPS - 1);
                end
            end
            RUN: begin
                if (xfer) begin
                    if (inner_max[NB_LOOPS]) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        for (int k = 0; k < NB_LOOPS; k++) begin
                            if (inner_max[k]) begin
                                idx_d[k] = at_max[k] ? '0 : idx_q[k] + ONE;
                                loop_d   = LW'(k);
                            end
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; clear returns everything to reset values
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            rng_q   <= '0;
            idx_q   <= '0;
            loop_q  <= '0;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= IDLE;
            rng_q   <= '0;
            idx_q   <= '0;
            loop_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rng_q   <= rng_d;
            idx_q   <= idx_d;
            loop_q  <= loop_d;
            done_q  <= done_d;
        end
    end

`ifdef HWPE_CTRL_NESTED_COUNTER_PERF_EN
    logic [31:0] perf_q;

    // Saturating count of accepted tuples, kept across jobs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (clear_i) begin
            perf_q <= '0;
        end else if (xfer && (perf_q != '1)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cnt_o = perf_q;
`else
    assign perf_cnt_o = '0;
`endif

endmodule
